// File: rtl/mips_fetch_unit.sv
// MIPS instruction fetch stage: owns the fetch PC, runs a req/ack handshake to instruction
// memory and buffers fetched words with their PCs in a DEPTH-entry prefetch queue that
// feeds decode over valid/ready. Decode redirects flush the queue and restart fetch.
// Optional feature: define FETCH_PERF_CNT_EN to build a saturating redirect counter;
// otherwise perf_flush_cnt is tied to zero.
module mips_fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [15:0] perf_flush_cnt
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StReq, StDrop} state_e;

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   drop_addr_q, drop_addr_d;
    logic [31:0]   inst_mem_q [DEPTH];
    logic [31:0]   pc_mem_q   [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next;
    logic [CW-1:0] count_q, count_d, count_after;
    logic          inst_valid_q, inst_valid_d;
    logic [31:0]   inst_q, inst_d, inst_pc_q, inst_pc_d;
    logic          push, pop;

    // Redirect outranks both queue operations
    assign pop  = inst_valid_q & inst_ready & ~redirect;
    assign push = (state_q == StReq) & imem_ack & ~redirect;
    assign count_after = count_q + CW'(push) - CW'(pop);
    assign rd_next = rd_ptr_q + PW'(pop);

    // FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= StIdle;
        else          state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (!redirect && count_q < FULL) state_d = StReq;
            StReq: begin
                if (redirect)      state_d = imem_ack ? StIdle : StDrop;
                else if (imem_ack) state_d = (count_after < FULL) ? StReq : StIdle;
            end
            StDrop: if (imem_ack) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: in DROP the abandoned address is held until memory acks it
    always_comb begin
        imem_req  = (state_q != StIdle);
        imem_addr = (state_q == StDrop) ? drop_addr_q : fetch_pc_q;
    end

    // Fetch PC, drop address and queue pointer next-state
    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        drop_addr_d = drop_addr_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            if (state_q == StReq && !imem_ack) drop_addr_d = fetch_pc_q;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) fetch_pc_d = fetch_pc_q + 32'd1;
            wr_ptr_d = wr_ptr_q + PW'(push);
            rd_ptr_d = rd_next;
            count_d  = count_after;
        end
    end

    // Next registered head: bypass the pushed word when it becomes the only entry
    always_comb begin
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        if (redirect || count_after == '0) begin
            inst_valid_d = 1'b0;
        end else begin
            inst_valid_d = 1'b1;
            if (count_q - CW'(pop) == '0) begin
                inst_d    = imem_rdata;
                inst_pc_d = fetch_pc_q;
            end else begin
                inst_d    = inst_mem_q[rd_next];
                inst_pc_d = pc_mem_q[rd_next];
            end
        end
    end

    // Control and head registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_q   <= RESET_PC;
            drop_addr_q  <= RESET_PC;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            inst_valid_q <= 1'b0;
            inst_q       <= 32'h0;
            inst_pc_q    <= 32'h0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            drop_addr_q  <= drop_addr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
        end
    end

    // Queue storage; contents are don't-care until written
    always_ff @(posedge clock) begin
        if (push) begin
            inst_mem_q[wr_ptr_q] <= imem_rdata;
            pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
        end
    end

    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] flush_cnt_q;

    // Saturating count of redirect cycles
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                                flush_cnt_q <= 16'h0;
        else if (redirect && flush_cnt_q != 16'hFFFF) flush_cnt_q <= flush_cnt_q + 16'd1;
    end

    assign perf_flush_cnt = flush_cnt_q;
`else
    assign perf_flush_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Bench for mips_fetch_unit: directed scenarios plus randomized traffic, all checked against
// a queue-based behavioural model every cycle, with literal expectations pinning the model.
module tb_mips_fetch_unit;
    localparam int unsigned DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        imem_req, imem_ack, inst_valid, inst_ready, redirect;
    logic [31:0] imem_addr, imem_rdata, inst, inst_pc, redirect_pc;
    logic [15:0] perf_flush_cnt;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    int nred  = 0;

    // Model state: mode 0=IDLE 1=REQ 2=DROP; queue entries are {pc, word}
    int          m_mode;
    logic [31:0] m_fpc, m_drop;
    logic [63:0] mq[$];
    int          m_perf;

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h0BAD_F00D;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    mips_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .perf_flush_cnt (perf_flush_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_mode = 0;
        m_fpc  = 32'h0;
        m_drop = 32'h0;
        mq.delete();
        m_perf = 0;
    endfunction

    // Advance the model by one clock edge using the inputs that were present at that edge
    function automatic void model_step();
        int sz;
        if (redirect) begin
            mq.delete();
            if (m_mode == 1) begin
                m_drop = m_fpc;
                m_mode = imem_ack ? 0 : 2;
            end else if (m_mode == 2 && imem_ack) begin
                m_mode = 0;
            end
            m_fpc = redirect_pc;
            if (m_perf < 65535) m_perf++;
        end else begin
            sz = mq.size();
            if (sz > 0 && inst_ready) void'(mq.pop_front());
            case (m_mode)
                0: if (sz < DEPTH) m_mode = 1;
                1: if (imem_ack) begin
                    mq.push_back({m_fpc, mem_word(m_fpc)});
                    m_fpc = m_fpc + 32'd1;
                    m_mode = (mq.size() < DEPTH) ? 1 : 0;
                end
                default: if (imem_ack) m_mode = 0;
            endcase
        end
    endfunction

    function automatic logic [15:0] exp_perf(input int n);
`ifdef FETCH_PERF_CNT_EN
        return 16'(n);
`else
        return 16'(n * 0);
`endif
    endfunction

    // Per-cycle comparison against the model
    always @(negedge clock) begin
        if (chk_en) begin
            chk("imem_req", {31'b0, imem_req}, {31'b0, m_mode != 0});
            if (m_mode != 0) chk("imem_addr", imem_addr, (m_mode == 2) ? m_drop : m_fpc);
            chk("inst_valid", {31'b0, inst_valid}, {31'b0, mq.size() > 0});
            if (mq.size() > 0) begin
                chk("inst_pc", inst_pc, mq[0][63:32]);
                chk("inst", inst, mq[0][31:0]);
            end
            chk("perf_flush_cnt", {16'b0, perf_flush_cnt}, {16'b0, exp_perf(m_perf)});
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
        model_step();
    endtask

    task automatic pulse_redirect(input logic [31:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        nred++;
        step();
        redirect = 1'b0;
    endtask

    initial begin
        int exp_pc, first_val, cnt, found;
        logic [31:0] nxt, pcs [2];

        reset_n = 1'b0; imem_ack = 1'b0; inst_ready = 1'b0;
        redirect = 1'b0; redirect_pc = 32'h0;
        model_reset();
        repeat (3) @(posedge clock);
        #2;
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'b0, inst_valid}, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_pc", inst_pc, 32'h0);
        chk("rst_perf", {16'b0, perf_flush_cnt}, 32'h0);
        @(negedge clock);
        #1 reset_n = 1'b1;
        chk_en = 1'b1;

        // 1: streaming, ack and ready always high
        imem_ack = 1'b1; inst_ready = 1'b1;
        exp_pc = 0; first_val = -1;
        for (int c = 0; c < 12; c++) begin
            step();
            if (inst_valid) begin
                if (first_val < 0) first_val = c;
                chk("p1_pc", inst_pc, exp_pc);
                chk("p1_inst", inst, mem_word(exp_pc));
                exp_pc++;
            end
        end
        // IDLE cycle, REQ+ack cycle, then the head is valid after the second edge
        chk("p1_first_valid", first_val, 1);
        nxt = exp_pc - 1;

        // 2: decode stalls, queue fills to DEPTH and fetch stops
        inst_ready = 1'b0;
        repeat (10) step();
        chk("p2_req_full", {31'b0, imem_req}, 32'h0);
        chk("p2_head", inst_pc, nxt);
        imem_ack = 1'b0; inst_ready = 1'b1;
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (inst_valid) begin
                chk("p2_drain_pc", inst_pc, nxt + cnt);
                cnt++;
            end
            step();
        end
        chk("p2_depth", cnt, DEPTH);

        // 3: delayed ack keeps the address stable, one push per ack
        for (int c = 0; c < 3; c++) begin
            chk("p3_addr_hold", imem_addr, nxt + 4);
            step();
        end
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        chk("p3_pushed", inst_pc, nxt + 4);
        chk("p3_next_addr", imem_addr, nxt + 5);
        step();
        chk("p3_single", {31'b0, inst_valid}, 32'h0);

        // 4: redirect with the request outstanding -> DROP on the old address
        pulse_redirect(32'h40);
        for (int c = 0; c < 3; c++) begin
            chk("p4_drop_req", {31'b0, imem_req}, 32'h1);
            chk("p4_drop_addr", imem_addr, nxt + 5);
            chk("p4_no_valid", {31'b0, inst_valid}, 32'h0);
            if (c < 2) step();
        end
        imem_ack = 1'b1;
        found = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (inst_valid && found == 0) begin
                found = 1;
                chk("p4_first_pc", inst_pc, 32'h40);
            end
        end
        chk("p4_seen", found, 1);

        // 5: redirect in the same cycle as ack and pop with two entries queued
        pulse_redirect(32'h100);
        inst_ready = 1'b0;
        for (int c = 0; c < 10 && mq.size() != 2; c++) step();
        chk("p5_two_queued", inst_pc, 32'h100);
        inst_ready = 1'b1;
        pulse_redirect(32'h200);
        chk("p5_flushed", {31'b0, inst_valid}, 32'h0);
        found = 0;
        for (int c = 0; c < 8 && found == 0; c++) begin
            step();
            if (inst_valid) begin
                found = 1;
                chk("p5_first_pc", inst_pc, 32'h200);
            end
        end
        chk("p5_seen", found, 1);

        // 6: PC wrap-around
        pulse_redirect(32'hFFFF_FFFF);
        cnt = 0;
        for (int c = 0; c < 10 && cnt < 2; c++) begin
            step();
            if (inst_valid) begin
                pcs[cnt] = inst_pc;
                cnt++;
            end
        end
        chk("p6_count", cnt, 2);
        chk("p6_pc0", pcs[0], 32'hFFFF_FFFF);
        chk("p6_pc1", pcs[1], 32'h0);
        chk("p6_perf", {16'b0, perf_flush_cnt}, {16'b0, exp_perf(nred)});

        // 7: randomized traffic
        for (int c = 0; c < 3000; c++) begin
            imem_ack    = ($urandom_range(0, 3) != 0);
            inst_ready  = ($urandom_range(0, 2) != 0);
            redirect    = ($urandom_range(0, 24) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 3)
                                                      : $urandom;
            step();
        end
        redirect = 1'b0;

        // 8: reset in the middle of a handshake drops the request immediately
        imem_ack = 1'b0; inst_ready = 1'b0;
        for (int c = 0; c < 10 && !imem_req; c++) step();
        chk("p8_req_before", {31'b0, imem_req}, 32'h1);
        chk_en = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("p8_req_dropped", {31'b0, imem_req}, 32'h0);
        chk("p8_valid", {31'b0, inst_valid}, 32'h0);
        chk("p8_addr", imem_addr, 32'h0);
        chk("p8_perf", {16'b0, perf_flush_cnt}, 32'h0);
        model_reset();
        @(negedge clock);
        #1 reset_n = 1'b1;
        chk_en = 1'b1;
        for (int c = 0; c < 300; c++) begin
            imem_ack    = ($urandom_range(0, 1) != 0);
            inst_ready  = ($urandom_range(0, 1) != 0);
            redirect    = ($urandom_range(0, 15) == 0);
            redirect_pc = $urandom;
            step();
        end
        redirect = 1'b0;
        @(negedge clock);
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
